sc_multi_charger: RTL
=====================

SC_MULTI_CHARGER -- requirements
Module: sc_multi_charger

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of charging channels (2..16).
REQ-002 SHALL have parameter MAX_ACTIVE, default 2, max channels with relay closed under NORMAL grid (1..N_CH).
REQ-003 SHALL have parameter SOFTSTART_CYC, default 8, cycles of relay-closed/charge-off precharge before charging (>=1).
REQ-004 SHALL have parameter FAULT_HOLD_CYC, default 16, consecutive NORMAL-grid cycles needed to clear a grid fault (>=1).
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port battery_connected  input  N_CH  per-channel battery presence.
REQ-008 SHALL have port battery_full  input  N_CH  per-channel battery-full indication.
REQ-009 SHALL have port grid_state  input  2  00 NORMAL, 01 SAG, 10 UNSTABLE, 11 OUTAGE.
REQ-010 SHALL have port ml_predict_instability  input  1  ML-model instability forecast.
REQ-011 SHALL have port charge_enable  output  N_CH  per-channel charging current enable.
REQ-012 SHALL have port relay_active  output  N_CH  per-channel relay closed.
REQ-013 SHALL have port active_count  output  $clog2(N_CH+1)  number of set relay_active bits.
REQ-014 SHALL have port fault_flag  output  1  high whenever fault_code != 0.
REQ-015 SHALL have port fault_code  output  4  0 none, 1 grid outage, 2 sensor inconsistency.

Function
REQ-016 Each channel SHALL run an FSM: IDLE, WAIT, SOFT, CHARGE, DONE; all outputs registered, reacting one cycle after the causing input.
REQ-017 IDLE->WAIT when connected and not full; WAIT requests a grant; relay_active=0, charge_enable=0 in IDLE, WAIT, DONE.
REQ-018 On grant, WAIT->SOFT: relay_active=1, charge_enable=0 for exactly SOFTSTART_CYC cycles, then SOFT->CHARGE: both 1.
REQ-019 battery_full in SOFT or CHARGE SHALL move the channel to DONE; DONE->IDLE only on disconnect.
REQ-020 Disconnect in any state SHALL move the channel to IDLE next cycle.
REQ-021 Arbiter SHALL issue at most one grant per cycle, round-robin, search starting at index after last granted channel (index 0 after reset).
REQ-022 Grant SHALL occur only if active_count < limit, fault_flag = 0, grid NORMAL or SAG.
REQ-023 limit SHALL be MAX_ACTIVE in NORMAL, max(1, MAX_ACTIVE/2) in SAG, 0 otherwise.
REQ-024 If active_count > limit in SAG, the highest-index active channels SHALL return to WAIT in one cycle until count equals limit.
REQ-025 UNSTABLE SHALL block new grants but keep SOFT/CHARGE channels running.
REQ-026 OUTAGE SHALL set fault_code=1 and return all SOFT/CHARGE channels to WAIT next cycle.
REQ-027 Grid fault SHALL clear only after FAULT_HOLD_CYC consecutive NORMAL cycles; any non-NORMAL cycle restarts the count.
REQ-028 battery_full=1 with battery_connected=0 on any channel SHALL set fault_code=2 (if no outage) and hold that channel in IDLE; code clears the cycle after the condition ends.
REQ-029 fault_code priority SHALL be outage over sensor inconsistency.
REQ-030 A channel leaving SOFT/CHARGE the same cycle another is granted SHALL be counted freed before the limit check.

Reset
REQ-031 reset SHALL asynchronously force all channels to IDLE, charge_enable=0, relay_active=0, active_count=0, fault_code=0, fault_flag=0, RR pointer to 0, hold and soft-start counters to 0.
REQ-032 reset asserted mid-charge SHALL open relays immediately, without waiting for a clock edge.

Configuration
REQ-033 With SC_ML_DERATE_EN defined, ml_predict_instability=1 SHALL reduce limit by one (floor 1 in NORMAL/SAG) and block grants for SOFT channels' completion; without it, ml_predict_instability SHALL be ignored.

Verification
REQ-034 N_CH=4, MAX_ACTIVE=2, all connected, grid NORMAL -> ch0, ch1 granted on consecutive cycles; relay 8 cycles before charge_enable; ch2, ch3 stay WAIT.
REQ-035 Two charging, grid to SAG -> ch1 returns to WAIT next cycle, active_count=1.
REQ-036 grid OUTAGE for 1 cycle then NORMAL -> fault_code=1, all relays open; fault clears after 16 NORMAL cycles, grants resume.
REQ-037 ch2 battery_full=1, connected=0 -> fault_code=2, fault_flag=1 next cycle; clears one cycle after removal.
REQ-038 ch0 full while charging -> DONE, relay opens, ch2 granted next cycle (RR order).
REQ-039 SC_ML_DERATE_EN defined, ml_predict_instability=1, NORMAL -> max one active channel; undefined -> two.

Source files
------------

// File: rtl/sc_multi_charger_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sc_multi_charger_if                                              |
// | Brief   : Battery/grid status inputs and charger control outputs.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface sc_multi_charger_if #(
    parameter int N_CH = 4
) ();
    localparam int CNT_W = $clog2(N_CH + 1);

    logic [N_CH-1:0]  battery_connected;
    logic [N_CH-1:0]  battery_full;
    logic [1:0]       grid_state;
    logic             ml_predict_instability;
    logic [N_CH-1:0]  charge_enable;
    logic [N_CH-1:0]  relay_active;
    logic [CNT_W-1:0] active_count;
    logic             fault_flag;
    logic [3:0]       fault_code;

    modport master (
        output battery_connected, battery_full, grid_state, ml_predict_instability,
        input  charge_enable, relay_active, active_count, fault_flag, fault_code
    );

    modport slave (
        input  battery_connected, battery_full, grid_state, ml_predict_instability,
        output charge_enable, relay_active, active_count, fault_flag, fault_code
    );
endinterface
`default_nettype wire

// File: rtl/sc_multi_charger.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sc_multi_charger                                                 |
// | Brief   : Grid-aware multi-channel charger with round-robin relay grants.  |
// |           Define SC_ML_DERATE_EN to derate on the ML instability forecast. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sc_multi_charger #(
    parameter int N_CH           = 4,
    parameter int MAX_ACTIVE     = 2,
    parameter int SOFTSTART_CYC  = 8,
    parameter int FAULT_HOLD_CYC = 16
) (
    input wire                clk,
    input wire                reset,
    sc_multi_charger_if.slave bus
);
    localparam int CNT_W     = $clog2(N_CH + 1);
    localparam int SS_W      = $clog2(SOFTSTART_CYC + 1);
    localparam int HOLD_W    = $clog2(FAULT_HOLD_CYC + 1);
    localparam int PTR_W     = $clog2(N_CH);
    localparam int SAG_LIMIT = (MAX_ACTIVE / 2 < 1) ? 1 : MAX_ACTIVE / 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_SOFT   = 3'd2;
    localparam logic [2:0] S_CHARGE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [1:0] G_NORMAL = 2'b00;
    localparam logic [1:0] G_SAG    = 2'b01;
    localparam logic [1:0] G_OUTAGE = 2'b11;

    localparam logic [3:0] FC_NONE   = 4'd0;
    localparam logic [3:0] FC_OUTAGE = 4'd1;
    localparam logic [3:0] FC_SENSOR = 4'd2;

    logic [2:0]        state_q  [N_CH];
    logic [2:0]        state_d  [N_CH];
    logic [SS_W-1:0]   ss_cnt_q [N_CH];
    logic [SS_W-1:0]   ss_cnt_d [N_CH];
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              grid_fault_q, grid_fault_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N_CH-1:0]   relay_q, relay_d;
    logic [N_CH-1:0]   charge_q, charge_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [3:0]        fcode_q, fcode_d;
    logic              fflag_q, fflag_d;

    logic              ml_active;
    logic              any_soft;
    logic              grant_ok;
    logic              granted;
    int                limit_int;
    int                kept;
    int                idx;

`ifdef SC_ML_DERATE_EN
    assign ml_active = bus.ml_predict_instability;
`else
    logic unused_ml;
    assign unused_ml = bus.ml_predict_instability;
    assign ml_active = 1'b0;
`endif

    // Grid fault latches on outage and needs an unbroken run of NORMAL cycles to clear
    always_comb begin
        grid_fault_d = grid_fault_q;
        hold_cnt_d   = '0;
        if (bus.grid_state == G_OUTAGE) begin
            grid_fault_d = 1'b1;
        end else if (grid_fault_q && bus.grid_state == G_NORMAL) begin
            if (hold_cnt_q == HOLD_W'(FAULT_HOLD_CYC - 1)) begin
                grid_fault_d = 1'b0;
            end else begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        any_soft = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (state_q[i] == S_SOFT) any_soft = 1'b1;
        end
        case (bus.grid_state)
            G_NORMAL: limit_int = MAX_ACTIVE;
            G_SAG:    limit_int = SAG_LIMIT;
            default:  limit_int = 0;
        endcase
        if (ml_active && limit_int > 1) limit_int = limit_int - 1;
    end

    // Next state: exits and sag shedding first, so freed slots are visible to the grant
    always_comb begin
        kept     = 0;
        granted  = 1'b0;
        idx      = 0;
        rr_ptr_d = rr_ptr_q;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i]  = state_q[i];
            ss_cnt_d[i] = ss_cnt_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (bus.battery_connected[i] && !bus.battery_full[i]) state_d[i] = S_WAIT;
                end
                S_WAIT: begin
                    if (!bus.battery_connected[i])  state_d[i] = S_IDLE;
                    else if (bus.battery_full[i])   state_d[i] = S_DONE;
                end
                S_SOFT, S_CHARGE: begin
                    ss_cnt_d[i] = '0;
                    if (!bus.battery_connected[i]) begin
                        state_d[i] = S_IDLE;
                    end else if (bus.battery_full[i]) begin
                        state_d[i] = S_DONE;
                    end else if (bus.grid_state == G_OUTAGE) begin
                        state_d[i] = S_WAIT;
                    end else if (bus.grid_state == G_SAG && kept >= limit_int) begin
                        state_d[i] = S_WAIT;
                    end else begin
                        kept = kept + 1;
                        if (state_q[i] == S_SOFT) begin
                            if (ss_cnt_q[i] == SS_W'(SOFTSTART_CYC - 1)) begin
                                state_d[i] = S_CHARGE;
                            end else begin
                                ss_cnt_d[i] = ss_cnt_q[i] + 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (!bus.battery_connected[i]) state_d[i] = S_IDLE;
                end
                default: state_d[i] = S_IDLE;
            endcase
        end

        grant_ok = !fflag_q && (bus.grid_state == G_NORMAL || bus.grid_state == G_SAG)
                   && (kept < limit_int) && !(ml_active && any_soft);
        if (grant_ok) begin
            for (int k = 0; k < N_CH; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= N_CH) idx = idx - N_CH;
                if (!granted && state_q[idx] == S_WAIT && bus.battery_connected[idx]
                    && !bus.battery_full[idx]) begin
                    state_d[idx]  = S_SOFT;
                    ss_cnt_d[idx] = '0;
                    granted       = 1'b1;
                    rr_ptr_d      = PTR_W'((idx == N_CH - 1) ? 0 : idx + 1);
                end
            end
        end
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            relay_d[i]  = (state_d[i] == S_SOFT) || (state_d[i] == S_CHARGE);
            charge_d[i] = (state_d[i] == S_CHARGE);
            count_d     = count_d + CNT_W'(relay_d[i]);
        end
        if (grid_fault_d)                                         fcode_d = FC_OUTAGE;
        else if (|(bus.battery_full & ~bus.battery_connected))    fcode_d = FC_SENSOR;
        else                                                      fcode_d = FC_NONE;
        fflag_d = (fcode_d != FC_NONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]  <= S_IDLE;
                ss_cnt_q[i] <= '0;
            end
            rr_ptr_q     <= '0;
            grid_fault_q <= 1'b0;
            hold_cnt_q   <= '0;
            relay_q      <= '0;
            charge_q     <= '0;
            count_q      <= '0;
            fcode_q      <= FC_NONE;
            fflag_q      <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]  <= state_d[i];
                ss_cnt_q[i] <= ss_cnt_d[i];
            end
            rr_ptr_q     <= rr_ptr_d;
            grid_fault_q <= grid_fault_d;
            hold_cnt_q   <= hold_cnt_d;
            relay_q      <= relay_d;
            charge_q     <= charge_d;
            count_q      <= count_d;
            fcode_q      <= fcode_d;
            fflag_q      <= fflag_d;
        end
    end

    assign bus.relay_active  = relay_q;
    assign bus.charge_enable = charge_q;
    assign bus.active_count  = count_q;
    assign bus.fault_code    = fcode_q;
    assign bus.fault_flag    = fflag_q;
endmodule
`default_nettype wire
